// File: rtl/long_divider_pkg.sv
// rtl/long_divider_pkg.sv - shared types and sizing helpers for the long divider
package long_divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREPARE,
        DIVIDE,
        FINISH
    } state_t;

    // Iteration counter width for a given operand width.
    function automatic int counter_width(input int data_width);
        return $clog2(data_width);
    endfunction

endpackage

// File: rtl/long_divider_stage.sv
// rtl/long_divider_stage.sv - one combinational restoring shift-subtract iteration
module long_divider_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH:0]   rem_i,
    input  logic                  shift_in_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH:0]   rem_o,
    output logic                  quot_bit_o
);

    logic [DATA_WIDTH+1:0] trial;

    // One extra bit on the trial difference so its MSB is the borrow.
    always_comb begin
        trial      = {rem_i, shift_in_i} - {2'b00, divisor_i};
        quot_bit_o = ~trial[DATA_WIDTH+1];
        rem_o      = quot_bit_o ? trial[DATA_WIDTH:0] : {rem_i[DATA_WIDTH-1:0], shift_in_i};
    end

endmodule

// File: rtl/long_divider.sv
// rtl/long_divider.sv - sequential restoring divider, signed/unsigned, quotient and remainder
module long_divider #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  clear_i,
    input  logic                  valid_i,
    input  logic                  signed_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic                  ready_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] quotient_o,
    output logic [DATA_WIDTH-1:0] remainder_o,
    output logic                  divide_by_zero_o
);
    import long_divider_pkg::*;

    localparam int CW = counter_width(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t                state_q, state_d;
    logic                  accept;
    logic [DATA_WIDTH-1:0] dividend_q, divisor_q;
    logic                  signed_q;
    logic [DATA_WIDTH:0]   p_q, p_next;
    logic [DATA_WIDTH-1:0] q_q;
    logic                  q_bit;
    logic [CW-1:0]         cnt_q;

    logic                  dividend_neg, divisor_neg, quot_neg, rem_neg;
    logic                  is_zero, is_ovf;
    logic [DATA_WIDTH-1:0] abs_dividend, abs_divisor;
    logic [DATA_WIDTH-1:0] fin_quotient, fin_remainder;
    logic                  fin_dbz;

    // Operands stay registered for the whole operation, so sign/abs/special-case
    // decoding is purely combinational from the captured values.
    always_comb begin
        dividend_neg = signed_q & dividend_q[DATA_WIDTH-1];
        divisor_neg  = signed_q & divisor_q[DATA_WIDTH-1];
        quot_neg     = dividend_neg ^ divisor_neg;
        rem_neg      = dividend_neg;
        abs_dividend = dividend_neg ? -dividend_q : dividend_q;
        abs_divisor  = divisor_neg ? -divisor_q : divisor_q;
        is_zero      = (divisor_q == '0);
        is_ovf       = signed_q && (dividend_q == MIN_VAL) && (divisor_q == '1);
    end

    always_comb begin
        fin_dbz = 1'b0;
        if (is_zero) begin
            fin_quotient  = '1;
            fin_remainder = dividend_q;
            fin_dbz       = 1'b1;
        end else if (is_ovf) begin
            fin_quotient  = MIN_VAL;
            fin_remainder = '0;
        end else begin
            fin_quotient  = quot_neg ? -q_q : q_q;
            fin_remainder = rem_neg ? -p_q[DATA_WIDTH-1:0] : p_q[DATA_WIDTH-1:0];
        end
    end

    long_divider_stage #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_stage (
        .rem_i      (p_q),
        .shift_in_i (q_q[DATA_WIDTH-1]),
        .divisor_i  (abs_divisor),
        .rem_o      (p_next),
        .quot_bit_o (q_bit)
    );

    assign ready_o = (state_q == IDLE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        accept  = 1'b1;
                        state_d = PREPARE;
                    end
                end
                PREPARE: state_d = (is_zero || is_ovf) ? FINISH : DIVIDE;
                DIVIDE:  if (cnt_q == '0) state_d = FINISH;
                FINISH:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dividend_q       <= '0;
            divisor_q        <= '0;
            signed_q         <= 1'b0;
            p_q              <= '0;
            q_q              <= '0;
            cnt_q            <= '0;
            valid_o          <= 1'b0;
            quotient_o       <= '0;
            remainder_o      <= '0;
            divide_by_zero_o <= 1'b0;
        end else begin
            valid_o <= (state_q == FINISH) && !clear_i;
            if (accept) begin
                dividend_q <= dividend_i;
                divisor_q  <= divisor_i;
                signed_q   <= signed_i;
            end
            if (!clear_i) begin
                case (state_q)
                    PREPARE: begin
                        p_q   <= '0;
                        q_q   <= abs_dividend;
                        cnt_q <= CW'(DATA_WIDTH - 1);
                    end
                    DIVIDE: begin
                        p_q <= p_next;
                        q_q <= {q_q[DATA_WIDTH-2:0], q_bit};
                        if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
                    end
                    FINISH: begin
                        quotient_o       <= fin_quotient;
                        remainder_o      <= fin_remainder;
                        divide_by_zero_o <= fin_dbz;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/long_divider.md
Name: long_divider

Overview:
- Sequential restoring long divider, the inverse datapath of the array long multiplier.
- Produces one quotient bit per clock from a single shift-subtract stage.
- Supports unsigned and two's-complement signed operands and returns both quotient and remainder.
- Sits beside the multiplier in the integer unit and shares its valid/ready issue style.

Parameters:
- DATA_WIDTH, 32, operand/result width in bits (>= 4).

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- clear_i  input  1  synchronous abort; returns the block to IDLE.
- valid_i  input  1  operands valid; accepted only when ready_o=1.
- signed_i  input  1  1 = signed division, 0 = unsigned.
- dividend_i  input  DATA_WIDTH  dividend.
- divisor_i  input  DATA_WIDTH  divisor.
- ready_o  output  1  block idle, will accept valid_i.
- valid_o  output  1  one-cycle pulse, results valid.
- quotient_o  output  DATA_WIDTH  quotient, held until next valid_o.
- remainder_o  output  DATA_WIDTH  remainder, held until next valid_o.
- divide_by_zero_o  output  1  divisor was zero, held with results.

Behaviour:
- Reset (rst_n_i low, asynchronous): state IDLE, ready_o=1, valid_o=0, quotient_o=0, remainder_o=0, divide_by_zero_o=0, counter=0.
- FSM states and transitions:
  - IDLE -> PREPARE on valid_i && ready_o. Operands and signed_i are registered; ready_o drops the next cycle.
  - PREPARE (1 cycle):
    - When signed, take the absolute value of both operands; record the quotient sign (sign xor) and the remainder sign (dividend sign).
    - Divisor zero -> FINISH with the zero flag set.
    - Signed dividend = MIN and divisor = -1 -> FINISH with the overflow flag set.
    - Otherwise load the partial remainder P (DATA_WIDTH+1 bits) = 0, Q = |dividend|, counter = DATA_WIDTH-1, then -> DIVIDE.
  - DIVIDE (DATA_WIDTH cycles), one iteration per cycle:
    - Shift {P,Q} left by 1.
    - T = P - {0,|divisor|}.
    - If T >= 0: P = T and Q[0] = 1; else Q[0] = 0.
    - Counter decrements; -> FINISH when counter = 0 after the final iteration.
  - FINISH (1 cycle): apply the rules below, register the outputs, pulse valid_o the following cycle, then -> IDLE.
    - Normal: quotient = Q, negated if the quotient sign is set; remainder = P[DATA_WIDTH-1:0], negated if the remainder sign is set.
    - Divide by zero: quotient = all ones, remainder = original dividend, divide_by_zero_o=1.
    - Overflow: quotient = MIN (1 followed by zeros), remainder = 0, divide_by_zero_o=0.
- Latency, with handshake in cycle T:
  - Normal: valid_o high in cycle T+DATA_WIDTH+3.
  - Zero and overflow fast paths: valid_o high in cycle T+3.
- ready_o is 1 only in IDLE, including the cycle valid_o is high. A new handshake in that cycle is legal, giving back-to-back operation.
- valid_i while busy is ignored; no queuing.
- The remainder always has the sign of the dividend, and |remainder| < |divisor|.
- clear_i has priority over all transitions:
  - Next state IDLE; valid_o is suppressed for the aborted operation.
  - Output registers keep their previous values.
- Asserting rst_n_i mid-operation returns the block to the reset values immediately.
- In unsigned mode the MIN/-1 check is disabled: 0x80000000 / 0xFFFFFFFF is a normal divide with quotient 0 and remainder 0x80000000.

Decomposition:
- Package long_divider_pkg:
  - State enum typedef (IDLE, PREPARE, DIVIDE, FINISH).
  - Counter width constant $clog2(DATA_WIDTH).
- Sub-module long_divider_stage: combinational single restoring iteration, mirroring the multiplier product row.
  - Inputs: partial remainder, dividend MSB shifted in, divisor.
  - Outputs: next partial remainder, quotient bit.
- The top level holds the FSM, counter, sign logic and output registers.

Test Plan (DATA_WIDTH=32):
- Unsigned 100 / 7 -> quotient 14, remainder 2, divide_by_zero_o=0; valid_o exactly 35 cycles after the handshake; ready_o low in between.
- Signed -7 / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Signed 7 / -2 -> quotient -3, remainder 1.
- 5 / 0, signed and unsigned -> quotient 0xFFFFFFFF, remainder 5, divide_by_zero_o=1; valid_o 3 cycles after the handshake.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, latency 3.
- Unsigned 0x80000000 / 0xFFFFFFFF -> quotient 0, remainder 0x80000000, full latency.
- Back-to-back: new valid_i in the valid_o cycle is accepted. valid_i pulses while busy are ignored; exactly one valid_o per accepted operation.
- clear_i at cycle 10 of a divide -> no valid_o; ready_o=1 next cycle; the previous outputs are unchanged.
- rst_n_i low mid-DIVIDE -> all outputs at reset values asynchronously.
- Random comparison against a reference model, 10k vectors, in both modes.
